// File: rtl/plc_link_table.sv
// plc_link_table: buffers (X, X') tuples in a small FIFO and writes them into a direct-mapped partner table.
// Define PLC_LINK_SYMMETRIC_EN to also record the reverse link X' -> X (adds the WR_REV state).
module plc_link_table #(
    parameter int ADDR_WIDTH = 8,
    parameter int WAY_WIDTH  = 4,
    parameter int IDX_WIDTH  = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          add_flag,
    input  logic [2*ADDR_WIDTH-1:0]       add_addr_tuple,
    input  logic [2*WAY_WIDTH-1:0]        add_way_tuple,
    input  logic                          lookup_req,
    input  logic [ADDR_WIDTH-1:0]         lookup_addr,
    input  logic [WAY_WIDTH-1:0]          lookup_way,
    output logic                          lookup_valid,
    output logic                          lookup_hit,
    output logic [ADDR_WIDTH-1:0]         partner_addr,
    output logic [WAY_WIDTH-1:0]          partner_way,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          ins_overflow,
    output logic                          busy,
    output logic [1:0]                    fsm_state
);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRIES = 1 << IDX_WIDTH;

`ifdef PLC_LINK_SYMMETRIC_EN
    typedef enum logic [1:0] {IDLE = 2'd0, WR_FWD = 2'd1, WR_REV = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, WR_FWD = 2'd1} state_t;
`endif

    state_t state;

    logic [2*ADDR_WIDTH-1:0] fifo_addr [FIFO_DEPTH];
    logic [2*WAY_WIDTH-1:0]  fifo_way  [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr, rd_ptr;

    logic [ENTRIES-1:0]      tbl_valid;
    logic [ADDR_WIDTH-1:0]   tbl_tag   [ENTRIES];
    logic [WAY_WIDTH-1:0]    tbl_tway  [ENTRIES];
    logic [ADDR_WIDTH-1:0]   tbl_paddr [ENTRIES];
    logic [WAY_WIDTH-1:0]    tbl_pway  [ENTRIES];

    logic [ADDR_WIDTH-1:0]   head_x, head_xp;
    logic [WAY_WIDTH-1:0]    head_wx, head_wxp;
    logic                    fifo_full, push, pop, wr_en, rd_hit;
    logic [ADDR_WIDTH-1:0]   wr_key, wr_partner;
    logic [WAY_WIDTH-1:0]    wr_kway, wr_pway;
    logic [IDX_WIDTH-1:0]    wr_idx, rd_idx;

    assign head_x   = fifo_addr[rd_ptr][2*ADDR_WIDTH-1:ADDR_WIDTH];
    assign head_xp  = fifo_addr[rd_ptr][ADDR_WIDTH-1:0];
    assign head_wx  = fifo_way[rd_ptr][2*WAY_WIDTH-1:WAY_WIDTH];
    assign head_wxp = fifo_way[rd_ptr][WAY_WIDTH-1:0];

    // Lookups own the cycle: a pending table write (and its pop) waits while lookup_req is high.
    always_comb begin
        fifo_full  = (fifo_count == CNT_W'(FIFO_DEPTH));
        wr_en      = 1'b0;
        pop        = 1'b0;
        wr_key     = head_x;
        wr_kway    = head_wx;
        wr_partner = head_xp;
        wr_pway    = head_wxp;
        if (!lookup_req) begin
            case (state)
                WR_FWD: begin
                    wr_en = 1'b1;
`ifndef PLC_LINK_SYMMETRIC_EN
                    pop   = 1'b1;
`endif
                end
`ifdef PLC_LINK_SYMMETRIC_EN
                WR_REV: begin
                    wr_en      = 1'b1;
                    pop        = 1'b1;
                    wr_key     = head_xp;
                    wr_kway    = head_wxp;
                    wr_partner = head_x;
                    wr_pway    = head_wx;
                end
`endif
                default: ;
            endcase
        end
        push = add_flag && (!fifo_full || pop);
    end

    assign wr_idx    = wr_key[IDX_WIDTH-1:0];
    assign rd_idx    = lookup_addr[IDX_WIDTH-1:0];
    assign rd_hit    = tbl_valid[rd_idx] && (tbl_tag[rd_idx] == lookup_addr) &&
                       (tbl_tway[rd_idx] == lookup_way);
    assign busy      = (fifo_count != '0) || (state != IDLE);
    assign fsm_state = state;

    // IDLE leaves as soon as a tuple is present or arriving, so the forward write can land at t+1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: if ((fifo_count != '0) || push) state <= WR_FWD;
`ifdef PLC_LINK_SYMMETRIC_EN
                WR_FWD: if (!lookup_req) state <= WR_REV;
                WR_REV: if (!lookup_req) state <= IDLE;
`else
                WR_FWD: if (!lookup_req) state <= IDLE;
`endif
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_count   <= '0;
            ins_overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      fifo_count <= fifo_count + CNT_W'(1);
            else if (pop && !push) fifo_count <= fifo_count - CNT_W'(1);
            if (add_flag && !push) ins_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= add_addr_tuple;
            fifo_way[wr_ptr]  <= add_way_tuple;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) tbl_valid <= '0;
        else if (wr_en) tbl_valid[wr_idx] <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tbl_tag[wr_idx]   <= wr_key;
            tbl_tway[wr_idx]  <= wr_kway;
            tbl_paddr[wr_idx] <= wr_partner;
            tbl_pway[wr_idx]  <= wr_pway;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lookup_valid <= 1'b0;
            lookup_hit   <= 1'b0;
            partner_addr <= '0;
            partner_way  <= '0;
        end else begin
            lookup_valid <= lookup_req;
            lookup_hit   <= lookup_req && rd_hit;
            partner_addr <= (lookup_req && rd_hit) ? tbl_paddr[rd_idx] : '0;
            partner_way  <= (lookup_req && rd_hit) ? tbl_pway[rd_idx] : '0;
        end
    end
endmodule

// File: tb/tb_plc_link_table.sv
// Bench for plc_link_table: directed cases plus randomized stall/drain rounds against a table model.
// Handshake: a lookup_req sampled at a rising edge yields lookup_valid for exactly the following cycle.
module tb_plc_link_table;
  localparam int AW = 8;
  localparam int WW = 4;
  localparam int IW = 4;
  localparam int DEPTH = 4;
  localparam int NENT = 1 << IW;
  localparam int RW = AW + WW + 1;
  localparam int TW = 2 * AW + 2 * WW;
  localparam int KW = AW + WW;
`ifdef PLC_LINK_SYMMETRIC_EN
  localparam bit SYM = 1'b1;
`else
  localparam bit SYM = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic add_flag;
  logic [2*AW-1:0] add_addr_tuple;
  logic [2*WW-1:0] add_way_tuple;
  logic lookup_req;
  logic [AW-1:0] lookup_addr;
  logic [WW-1:0] lookup_way;
  logic lookup_valid, lookup_hit;
  logic [AW-1:0] partner_addr;
  logic [WW-1:0] partner_way;
  logic [$clog2(DEPTH):0] fifo_count;
  logic ins_overflow, busy;
  logic [1:0] fsm_state;

  plc_link_table #(.ADDR_WIDTH(AW), .WAY_WIDTH(WW), .IDX_WIDTH(IW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .add_flag(add_flag), .add_addr_tuple(add_addr_tuple),
    .add_way_tuple(add_way_tuple), .lookup_req(lookup_req), .lookup_addr(lookup_addr),
    .lookup_way(lookup_way), .lookup_valid(lookup_valid), .lookup_hit(lookup_hit),
    .partner_addr(partner_addr), .partner_way(partner_way), .fifo_count(fifo_count),
    .ins_overflow(ins_overflow), .busy(busy), .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  logic [RW-1:0] exp_q[$];

  // reference model: direct-mapped partner table plus the list of accepted, not-yet-written tuples
  bit m_valid[NENT];
  logic [AW-1:0] m_tag[NENT];
  logic [AW-1:0] m_pa[NENT];
  logic [WW-1:0] m_tw[NENT];
  logic [WW-1:0] m_pw[NENT];
  logic [TW-1:0] pend_q[$];
  logic [KW-1:0] pool[$];
  bit ov_exp = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic void model_write(input logic [AW-1:0] k, input logic [WW-1:0] kw,
                                      input logic [AW-1:0] p, input logic [WW-1:0] pw);
    int i;
    i = int'(k[IW-1:0]);
    m_valid[i] = 1'b1;
    m_tag[i] = k;
    m_tw[i] = kw;
    m_pa[i] = p;
    m_pw[i] = pw;
  endfunction

  function automatic void apply_pending();
    logic [TW-1:0] t;
    while (pend_q.size() > 0) begin
      t = pend_q.pop_front();
      model_write(t[TW-1 -: AW], t[2*WW-1 -: WW], t[TW-AW-1 -: AW], t[WW-1:0]);
      if (SYM) model_write(t[TW-AW-1 -: AW], t[WW-1:0], t[TW-1 -: AW], t[2*WW-1 -: WW]);
    end
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < NENT; i++) m_valid[i] = 1'b0;
    pend_q.delete();
    ov_exp = 1'b0;
  endfunction

  function automatic logic [RW-1:0] model_lookup(input logic [AW-1:0] a, input logic [WW-1:0] w);
    int i;
    i = int'(a[IW-1:0]);
    if (m_valid[i] && m_tag[i] == a && m_tw[i] == w) return {1'b1, m_pa[i], m_pw[i]};
    return '0;
  endfunction

  // driver: one clock of stimulus; the expected lookup result is queued as the request is sampled
  task automatic step(input bit add, input logic [2*AW-1:0] at, input logic [2*WW-1:0] wt,
                      input bit req, input logic [AW-1:0] la, input logic [WW-1:0] lw);
    logic [RW-1:0] e;
    add_flag = add;
    add_addr_tuple = at;
    add_way_tuple = wt;
    lookup_req = req;
    lookup_addr = la;
    lookup_way = lw;
    e = model_lookup(la, lw);
    if (add) begin
      if (pend_q.size() < DEPTH) begin
        pend_q.push_back({at, wt});
        pool.push_back({at[2*AW-1:AW], wt[2*WW-1:WW]});
        pool.push_back({at[AW-1:0], wt[WW-1:0]});
      end else begin
        ov_exp = 1'b1;
      end
    end
    @(posedge clk);
    if (req) exp_q.push_back(e);
    #1;
    add_flag = 1'b0;
    lookup_req = 1'b0;
  endtask

  task automatic idle();
    step(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  task automatic lk(input logic [AW-1:0] a, input logic [WW-1:0] w);
    step(1'b0, '0, '0, 1'b1, a, w);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 64) begin
      idle();
      n++;
    end
    check("drain_busy", busy, 0);
    check("drain_count", fifo_count, 0);
    apply_pending();
  endtask

  function automatic logic [KW-1:0] rand_key();
    logic [KW-1:0] k;
    if (pool.size() > 0 && $urandom_range(0, 2) != 0) begin
      k = pool[$urandom_range(0, pool.size() - 1)];
      if ($urandom_range(0, 5) == 0) k[WW-1:0] = k[WW-1:0] + WW'(1);
    end else begin
      k = KW'($urandom_range(0, (1 << KW) - 1));
    end
    return k;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, lookup_valid, 0);
    check({tag, "_hit"}, lookup_hit, 0);
    check({tag, "_paddr"}, partner_addr, 0);
    check({tag, "_pway"}, partner_way, 0);
    check({tag, "_count"}, fifo_count, 0);
    check({tag, "_ovf"}, ins_overflow, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_state"}, fsm_state, 0);
  endtask

  // scoreboard monitor: every queued expectation is due at the negedge after it was queued
  always @(negedge clk) begin
    logic [RW-1:0] got;
    logic [RW-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      got = {lookup_hit, partner_addr, partner_way};
      vectors++;
      if (!lookup_valid) begin
        miscompares++;
        $display("FAIL lookup_missing: lookup_valid=0, expected result %0h", e);
      end else if (got !== e) begin
        miscompares++;
        $display("FAIL lookup_result: got {hit,paddr,pway}=%0h, expected %0h", got, e);
      end
    end else if (lookup_valid) begin
      vectors++;
      miscompares++;
      $display("FAIL lookup_unexpected: lookup_valid=1 with no request outstanding");
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [KW-1:0] k;
    logic [2*AW-1:0] at;
    logic [2*WW-1:0] wt;
    int n;

    rst = 1'b1;
    add_flag = 1'b0;
    add_addr_tuple = '0;
    add_way_tuple = '0;
    lookup_req = 1'b0;
    lookup_addr = '0;
    lookup_way = '0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    idle();

    // basic insert: forward entry visible two cycles after add_flag
    step(1'b1, 16'h1234, 8'h35, 1'b0, '0, '0);
    idle();
    apply_pending();
    lk(8'h12, 4'h3);
    wait_idle();
    lk(8'h34, 4'h5);
    // tag / way mismatch on the same index
    lk(8'h22, 4'h3);
    lk(8'h12, 4'h4);
    lk(8'h12, 4'h3);
    idle();

    // lookup stall: 10 held lookups while four tuples arrive; the table must not change
    for (int i = 0; i < 10; i++) begin
      if (i >= 1 && i <= 4)
        step(1'b1, {8'h52 + 8'(i - 1) * 8'h11, 8'hc8 + 8'(i - 1)}, 8'(i * 16 + 7), 1'b1, 8'h12, 4'h3);
      else
        lk(8'h12, 4'h3);
    end
    check("stall_count", fifo_count, 4);
    check("stall_busy", busy, 1);
    check("stall_state", fsm_state, 1);
    check("stall_ovf", ins_overflow, 0);
    wait_idle();
    lk(8'h12, 4'h3);
    for (int i = 0; i < 4; i++) lk(8'h52 + 8'(i) * 8'h11, 4'(i + 1));
    for (int i = 0; i < 4; i++) lk(8'hc8 + 8'(i), 4'h7);
    idle();

    // overflow: five tuples into a stalled four-deep FIFO
    lk(8'h00, 4'h0);
    for (int i = 0; i < 5; i++)
      step(1'b1, {8'h80 + 8'(i), 8'h38 + 8'(i)}, {4'(i), 4'(15 - i)}, 1'b1, 8'h12, 4'h3);
    check("ovf_count", fifo_count, 4);
    check("ovf_flag", ins_overflow, 1);
    wait_idle();
    for (int i = 0; i < 5; i++) begin
      lk(8'h80 + 8'(i), 4'(i));
      lk(8'h38 + 8'(i), 4'(15 - i));
    end
    check("ovf_sticky", ins_overflow, 1);

    // randomized stall / drain / lookup rounds
    for (int r = 0; r < 12; r++) begin
      k = rand_key();
      lk(k[KW-1:WW], k[WW-1:0]);
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        at = 16'($urandom_range(0, 16'hffff));
        wt = 8'($urandom_range(0, 8'hff));
        k = rand_key();
        step(1'b1, at, wt, 1'b1, k[KW-1:WW], k[WW-1:0]);
      end
      check("rnd_count", fifo_count, pend_q.size());
      check("rnd_ovf", ins_overflow, ov_exp);
      wait_idle();
      for (int i = 0; i < 8; i++) begin
        k = rand_key();
        lk(k[KW-1:WW], k[WW-1:0]);
      end
    end

    // reset while the FSM sits in WR_FWD with two tuples queued
    lk(8'h12, 4'h3);
    step(1'b1, 16'h0a0b, 8'h12, 1'b1, 8'h12, 4'h3);
    step(1'b1, 16'h0c0d, 8'h34, 1'b1, 8'h12, 4'h3);
    check("rstmid_count", fifo_count, 2);
    check("rstmid_state", fsm_state, 1);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_reset_outputs("rstmid");
    model_clear();
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle();
    for (int i = 0; i < pool.size(); i++) begin
      k = pool[i];
      lk(k[KW-1:WW], k[WW-1:0]);
    end
    repeat (3) idle();
    check("exp_q_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
